// File: rtl/urna_controle.sv
// Vote-entry controller: two-digit BCD candidate entry, review, commit and
// per-candidate tallying, with 7-segment decode of both digits.
module urna_controle #(
  parameter int         CNT_W     = 8,
  parameter logic [7:0] CAND_A    = 8'h13,
  parameter logic [7:0] CAND_B    = 8'h45,
  parameter int         CONF_HOLD = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key1,
  input  logic             key2,
  input  logic             key3,
  output logic [3:0]       bcd1,
  output logic [3:0]       bcd2,
  output logic [6:0]       hex1,
  output logic [6:0]       hex2,
  output logic [2:0]       estado,
  output logic             voto_ok,
  output logic [CNT_W-1:0] cnt_a,
  output logic [CNT_W-1:0] cnt_b,
  output logic [CNT_W-1:0] cnt_nulo
);

  localparam int TMR_W = (CONF_HOLD > 1) ? $clog2(CONF_HOLD) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(CONF_HOLD - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [2:0] {
    DIG1   = 3'd0,
    DIG2   = 3'd1,
    REVISA = 3'd2,
    GRAVA  = 3'd3,
    FIM    = 3'd4
  } state_t;

  state_t           state_r, state_s;
  logic [2:0]       key_q_r;
  logic [2:0]       key_s;
  logic [2:0]       ev_s;
  logic             cancel_s, advance_s, inc_s;
  logic [3:0]       bcd1_r, bcd1_s, bcd2_r, bcd2_s;
  logic [TMR_W-1:0] timer_r, timer_s;
  logic             tmr_done_s;
  logic             voto_ok_r, voto_ok_s;
  logic [CNT_W-1:0] cnt_a_r, cnt_a_s, cnt_b_r, cnt_b_s, cnt_nulo_r, cnt_nulo_s;
  logic [7:0]       code_s;

  function automatic logic [3:0] digit_inc(input logic [3:0] d);
    return (d == 4'd9) ? 4'd0 : d + 4'd1;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_MAX) ? c : c + CNT_W'(1);
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  // key_q resets to 1 so a key already held through reset never fires
  assign key_s      = {key3, key2, key1};
  assign ev_s       = key_s & ~key_q_r;
  assign cancel_s   = ev_s[2];
  assign advance_s  = ev_s[1] & ~ev_s[2];
  assign inc_s      = ev_s[0] & ~ev_s[1] & ~ev_s[2];
  assign tmr_done_s = (timer_r == TMR_LAST);
  assign code_s     = {bcd1_r, bcd2_r};

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= DIG1;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_s = DIG1;
    case (state_r)
      DIG1: begin
        if (cancel_s)       state_s = DIG1;
        else if (advance_s) state_s = DIG2;
        else                state_s = DIG1;
      end
      DIG2: begin
        if (cancel_s)       state_s = DIG1;
        else if (advance_s) state_s = REVISA;
        else                state_s = DIG2;
      end
      REVISA: begin
        if (cancel_s)       state_s = DIG1;
        else if (advance_s) state_s = GRAVA;
        else                state_s = REVISA;
      end
      GRAVA:   state_s = FIM;
      FIM: begin
        if (tmr_done_s) state_s = DIG1;
        else            state_s = FIM;
      end
      default: state_s = DIG1;
    endcase
  end

  // Output/datapath next values: digits, FIM timer, tallies and commit pulse
  always_comb begin
    bcd1_s     = bcd1_r;
    bcd2_s     = bcd2_r;
    timer_s    = '0;
    voto_ok_s  = 1'b0;
    cnt_a_s    = cnt_a_r;
    cnt_b_s    = cnt_b_r;
    cnt_nulo_s = cnt_nulo_r;
    case (state_r)
      DIG1: begin
        if (cancel_s)   bcd1_s = 4'd0;
        else if (inc_s) bcd1_s = digit_inc(bcd1_r);
        else            bcd1_s = bcd1_r;
      end
      DIG2: begin
        if (cancel_s) begin
          bcd1_s = 4'd0;
          bcd2_s = 4'd0;
        end else if (inc_s) begin
          bcd2_s = digit_inc(bcd2_r);
        end else begin
          bcd2_s = bcd2_r;
        end
      end
      REVISA: begin
        if (cancel_s) begin
          bcd1_s = 4'd0;
          bcd2_s = 4'd0;
        end else begin
          bcd1_s = bcd1_r;
        end
      end
      GRAVA: begin
        voto_ok_s = 1'b1;
        if (code_s == CAND_A)      cnt_a_s    = sat_inc(cnt_a_r);
        else if (code_s == CAND_B) cnt_b_s    = sat_inc(cnt_b_r);
        else                       cnt_nulo_s = sat_inc(cnt_nulo_r);
      end
      FIM: begin
        if (tmr_done_s) begin
          bcd1_s  = 4'd0;
          bcd2_s  = 4'd0;
          timer_s = '0;
        end else begin
          timer_s = timer_r + TMR_W'(1);
        end
      end
      default: begin
        bcd1_s = 4'd0;
        bcd2_s = 4'd0;
      end
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      key_q_r    <= 3'b111;
      bcd1_r     <= 4'd0;
      bcd2_r     <= 4'd0;
      timer_r    <= '0;
      voto_ok_r  <= 1'b0;
      cnt_a_r    <= '0;
      cnt_b_r    <= '0;
      cnt_nulo_r <= '0;
    end else begin
      key_q_r    <= key_s;
      bcd1_r     <= bcd1_s;
      bcd2_r     <= bcd2_s;
      timer_r    <= timer_s;
      voto_ok_r  <= voto_ok_s;
      cnt_a_r    <= cnt_a_s;
      cnt_b_r    <= cnt_b_s;
      cnt_nulo_r <= cnt_nulo_s;
    end
  end

  assign bcd1     = bcd1_r;
  assign bcd2     = bcd2_r;
  assign hex1     = seg7(bcd1_r);
  assign hex2     = seg7(bcd2_r);
  assign estado   = state_r;
  assign voto_ok  = voto_ok_r;
  assign cnt_a    = cnt_a_r;
  assign cnt_b    = cnt_b_r;
  assign cnt_nulo = cnt_nulo_r;

endmodule

// File: tb/tb_urna_controle.sv
// Directed bench for urna_controle: a default instance and a CNT_W=2 instance
// share the same key stimulus so saturation is reached in a few votes.
module tb_urna_controle;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, key1, key2, key3;
  logic [3:0] bcd1, bcd2, s_bcd1, s_bcd2;
  logic [6:0] hex1, hex2, s_hex1, s_hex2;
  logic [2:0] estado, s_estado;
  logic       voto_ok, s_voto_ok;
  logic [7:0] cnt_a, cnt_b, cnt_nulo;
  logic [1:0] s_cnt_a, s_cnt_b, s_cnt_nulo;

  int errors = 0;
  int checks = 0;
  int pulses_big = 0;
  int pulses_small = 0;
  int ea = 0, eb = 0, en = 0;
  int sa = 0, sb = 0, sn = 0;

  urna_controle dut (
    .clk(clk), .rst(rst), .key1(key1), .key2(key2), .key3(key3),
    .bcd1(bcd1), .bcd2(bcd2), .hex1(hex1), .hex2(hex2), .estado(estado),
    .voto_ok(voto_ok), .cnt_a(cnt_a), .cnt_b(cnt_b), .cnt_nulo(cnt_nulo)
  );

  urna_controle #(.CNT_W(2)) dut_small (
    .clk(clk), .rst(rst), .key1(key1), .key2(key2), .key3(key3),
    .bcd1(s_bcd1), .bcd2(s_bcd2), .hex1(s_hex1), .hex2(s_hex2), .estado(s_estado),
    .voto_ok(s_voto_ok), .cnt_a(s_cnt_a), .cnt_b(s_cnt_b), .cnt_nulo(s_cnt_nulo)
  );

  always @(negedge clk) begin
    if (voto_ok)   pulses_big   <= pulses_big + 1;
    if (s_voto_ok) pulses_small <= pulses_small + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_key(input int k, input logic v);
    case (k)
      1: key1 = v;
      2: key2 = v;
      3: key3 = v;
      default: ;
    endcase
  endtask

  task automatic press(input int k);
    set_key(k, 1'b1);
    tick();
    set_key(k, 1'b0);
    tick();
  endtask

  task automatic enter(input int d1, input int d2);
    for (int i = 0; i < d1; i++) press(1);
    press(2);
    for (int i = 0; i < d2; i++) press(1);
    press(2);
  endtask

  task automatic chk_counts(input string tag);
    chk({tag, "_cnt_a"}, cnt_a, ea);
    chk({tag, "_cnt_b"}, cnt_b, eb);
    chk({tag, "_cnt_nulo"}, cnt_nulo, en);
    chk({tag, "_s_cnt_a"}, s_cnt_a, sa);
    chk({tag, "_s_cnt_b"}, s_cnt_b, sb);
    chk({tag, "_s_cnt_nulo"}, s_cnt_nulo, sn);
  endtask

  // Full entry + commit + FIM hold, with key presses during FIM that must be ignored
  task automatic vote(input int d1, input int d2, input string tag);
    logic [7:0] code;
    enter(d1, d2);
    chk({tag, "_revisa"}, estado, 3'd2);
    chk({tag, "_bcd1"}, bcd1, d1);
    chk({tag, "_bcd2"}, bcd2, d2);
    code = 8'(d1 * 16 + d2);
    if (code == 8'h13) begin
      ea++;
      if (sa < 3) sa++;
    end else if (code == 8'h45) begin
      eb++;
      if (sb < 3) sb++;
    end else begin
      en++;
      if (sn < 3) sn++;
    end
    key2 = 1'b1;
    tick();
    chk({tag, "_grava"}, estado, 3'd3);
    chk({tag, "_ok_pre"}, voto_ok, 1'b0);
    key2 = 1'b0;
    tick();
    chk({tag, "_fim"}, estado, 3'd4);
    chk({tag, "_ok"}, voto_ok, 1'b1);
    chk_counts(tag);
    key1 = 1'b1;
    tick();
    chk({tag, "_ok_low"}, voto_ok, 1'b0);
    chk({tag, "_hold_bcd1"}, bcd1, d1);
    key1 = 1'b0;
    key2 = 1'b1;
    tick();
    chk({tag, "_fim3"}, estado, 3'd4);
    key2 = 1'b0;
    tick();
    chk({tag, "_fim4"}, estado, 3'd4);
    chk({tag, "_fim4_bcd2"}, bcd2, d2);
    tick();
    chk({tag, "_back"}, estado, 3'd0);
    chk({tag, "_clr1"}, bcd1, 4'd0);
    chk({tag, "_clr2"}, bcd2, 4'd0);
  endtask

  initial begin
    rst = 1'b1; key1 = 1'b1; key2 = 1'b1; key3 = 1'b1;
    tick(); tick(); tick();
    chk("rst_estado", estado, 3'd0);
    chk("rst_bcd1", bcd1, 4'd0);
    chk("rst_bcd2", bcd2, 4'd0);
    chk("rst_hex1", hex1, 7'b1000000);
    chk("rst_hex2", hex2, 7'b1000000);
    chk("rst_ok", voto_ok, 1'b0);
    chk_counts("rst");

    // Keys held high through reset release must not fire
    rst = 1'b0;
    tick(); tick(); tick();
    chk("held_estado", estado, 3'd0);
    chk("held_bcd1", bcd1, 4'd0);
    key1 = 1'b0; key2 = 1'b0; key3 = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) press(1);
    chk("k1x3_bcd1", bcd1, 4'd3);
    chk("k1x3_hex1", hex1, 7'b0110000);
    chk("k1x3_estado", estado, 3'd0);

    press(3);
    chk("dig1_cancel_bcd1", bcd1, 4'd0);
    chk("dig1_cancel_estado", estado, 3'd0);

    for (int i = 0; i < 9; i++) press(1);
    chk("k1x9_bcd1", bcd1, 4'd9);
    chk("k1x9_hex1", hex1, 7'b0010000);
    press(1);
    chk("wrap_bcd1", bcd1, 4'd0);
    chk("wrap_hex1", hex1, 7'b1000000);

    // key2 beats key1 in DIG1; key3 beats key2 in DIG2
    press(1); press(1);
    key1 = 1'b1; key2 = 1'b1;
    tick();
    chk("k2_over_k1_estado", estado, 3'd1);
    chk("k2_over_k1_bcd1", bcd1, 4'd2);
    key1 = 1'b0; key2 = 1'b0;
    tick();
    press(1);
    chk("dig2_bcd2", bcd2, 4'd1);
    chk("dig2_hex2", hex2, 7'b1111001);
    key2 = 1'b1; key3 = 1'b1;
    tick();
    chk("k3_over_k2_estado", estado, 3'd0);
    chk("k3_over_k2_bcd1", bcd1, 4'd0);
    chk("k3_over_k2_bcd2", bcd2, 4'd0);
    key2 = 1'b0; key3 = 1'b0;
    tick();

    vote(1, 3, "vote_a");
    vote(4, 5, "vote_b");
    vote(9, 9, "vote_nulo");

    enter(2, 7);
    chk("rev_estado", estado, 3'd2);
    press(1);
    chk("rev_k1_ignored", bcd2, 4'd7);
    press(3);
    chk("rev_cancel_estado", estado, 3'd0);
    chk("rev_cancel_bcd1", bcd1, 4'd0);
    chk("rev_cancel_bcd2", bcd2, 4'd0);
    chk_counts("rev_cancel");

    for (int i = 0; i < 5; i++) vote(1, 3, "sat_a");
    chk("big_cnt_a6", cnt_a, 8'd6);
    chk("small_cnt_a3", s_cnt_a, 2'd3);
    chk("pulses_big", pulses_big, 8);
    chk("pulses_small", pulses_small, 8);

    // Reset asserted while in FIM clears everything
    enter(4, 5);
    key2 = 1'b1;
    tick();
    key2 = 1'b0;
    tick();
    chk("pre_rst_fim", estado, 3'd4);
    rst = 1'b1;
    tick();
    ea = 0; eb = 0; en = 0; sa = 0; sb = 0; sn = 0;
    chk("fim_rst_estado", estado, 3'd0);
    chk("fim_rst_ok", voto_ok, 1'b0);
    chk("fim_rst_bcd1", bcd1, 4'd0);
    chk("fim_rst_bcd2", bcd2, 4'd0);
    chk("fim_rst_s_estado", s_estado, 3'd0);
    chk_counts("fim_rst");
    rst = 1'b0;
    tick(); tick();
    chk("post_rst_estado", estado, 3'd0);
    chk_counts("post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/urna_controle.md
# urna_controle

Vote-entry controller for the URNA voting machine. Sequences two-digit candidate entry from the push keys and drives both 7-segment digits. On confirmation, tallies the vote into per-candidate counters. Sits between the board keys and the digit/display path, replacing free-running digit logic with a state-sequenced entry/review/commit flow.

## Interface

Parameters:
- CNT_W, 8: width of each vote counter.
- CAND_A, 8'h13: BCD code of candidate A ({tens, units}).
- CAND_B, 8'h45: BCD code of candidate B.
- CONF_HOLD, 4: cycles spent in FIM before returning to entry; must be ≥ 1.

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst  in  1  reset; synchronous, active-high.
- key1  in  1  increment current digit (level input, rising-edge detected).
- key2  in  1  advance / confirm (rising-edge detected).
- key3  in  1  correct / cancel (rising-edge detected).
- bcd1  out  4  tens digit, 0–9.
- bcd2  out  4  units digit, 0–9.
- hex1  out  7  7-seg of bcd1, active-low, bit order gfedcba.
- hex2  out  7  7-seg of bcd2, same encoding.
- estado  out  3  FSM state code.
- voto_ok  out  1  one-cycle pulse when a vote is recorded.
- cnt_a, cnt_b, cnt_nulo  out  CNT_W  vote tallies.

## Operation

- Edge detection:
  - Each key has a registered previous sample, reset to 1.
  - event = key & ~key_q, so a key held during and after reset never fires.
  - One event per low→high transition.
- Event priority in the same cycle: key3 > key2 > key1. Only the highest-priority event acts; the others are dropped.
- FSM states (estado code):
  - DIG1 (0):
    - key1: bcd1 ← bcd1==9 ? 0 : bcd1+1.
    - key2: → DIG2.
    - key3: bcd1 ← 0, stay in DIG1.
  - DIG2 (1):
    - key1: increments bcd2 with the same 9→0 wrap.
    - key2: → REVISA.
    - key3: bcd1 ← 0, bcd2 ← 0, → DIG1.
  - REVISA (2):
    - key2: → GRAVA.
    - key3: clear both digits, → DIG1.
    - key1 ignored.
  - GRAVA (3):
    - Lasts exactly one cycle, all keys ignored.
    - Code {bcd1,bcd2}: ==CAND_A → cnt_a+1; ==CAND_B → cnt_b+1; otherwise cnt_nulo+1.
    - → FIM.
  - FIM (4):
    - Keys ignored; digits held.
    - After CONF_HOLD cycles: bcd1 ← 0, bcd2 ← 0, → DIG1.
  - Codes 5–7 are unreachable. If ever entered, the FSM goes to DIG1 on the next edge.
- Counters saturate at 2^CNT_W−1. A vote for a saturated counter still pulses voto_ok but leaves the count unchanged.
- hex encoding, combinational from bcd:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001.
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
- Reset values:
  - State DIG1; bcd1 = bcd2 = 0; hex1 = hex2 = 1000000.
  - All counters 0; voto_ok 0; key_q all 1; FIM timer 0.
- Reset mid-operation (any state, including GRAVA/FIM): everything returns to reset values at that edge. No vote is recorded.

## Timing

- Key reaction:
  - Key low at edge N−1 and high at edge N → action visible after edge N.
  - A key pulse must be high for at least one sampled edge.
- Commit sequence:
  - key2 event at edge N in REVISA → estado=GRAVA after N.
  - After N+1: counter updated, voto_ok=1, estado=FIM.
  - After N+2: voto_ok=0.
  - After N+1+CONF_HOLD: estado=DIG1, digits 0.
- voto_ok is registered, high exactly one cycle per recorded vote.
- Minimum full vote with keys only: 2 key2 events to reach REVISA + 1 confirm + 1 + CONF_HOLD cycles.

## Test plan

- Reset with key1=key2=key3=1 held → no events. Drop key1, raise it ×3 → bcd1=3, hex1=0110000, estado=0.
- Enter bcd1=1 and bcd2=3, then key2 to REVISA, then key2 → voto_ok pulses one cycle; cnt_a=1, cnt_b=0, cnt_nulo=0; with CONF_HOLD=4, estado=0 and digits 0 four cycles later.
- Enter 4,5 and confirm → cnt_b=1. Enter 9,9 and confirm → cnt_nulo=1.
- key1 ×10 in DIG1 → bcd1 wraps to 0. key3 in REVISA → estado=0, bcd1=bcd2=0, no counter changes.
- key2 and key3 rising in the same cycle in DIG2 → cancel wins (estado=0). Key presses during FIM are ignored.
- With CNT_W=2, record 5 votes for CAND_A → cnt_a=3 and 5 voto_ok pulses. Assert rst during FIM → all counters 0, estado=0.
